// File: rtl/layer_2_channel_packer_if.sv
// -----------------------------------------------------------------------------
// layer_2_channel_packer_if
// Groups the stream signals of the layer-2 channel packer.
//   data_in / valid_in / ready_out : channel-serial input handshake
//   data_out / valid_out           : packed pixel word, one-cycle valid pulse
//   pixel_x / pixel_y / frame_done : raster position of the pixel on data_out
// Modports:
//   master : upstream feeder and downstream consumer side (drives data_in/valid_in)
//   slave  : the packer itself
// -----------------------------------------------------------------------------
interface layer_2_channel_packer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int DATA_IN_WIDTH = 512,
   parameter int COORD_WIDTH   = 8
);
   logic [DATA_WIDTH-1:0]    data_in;
   logic                     valid_in;
   logic                     ready_out;
   logic [DATA_IN_WIDTH-1:0] data_out;
   logic                     valid_out;
   logic [COORD_WIDTH-1:0]   pixel_x;
   logic [COORD_WIDTH-1:0]   pixel_y;
   logic                     frame_done;

   modport master (
      output data_in, valid_in,
      input  ready_out, data_out, valid_out, pixel_x, pixel_y, frame_done
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, data_out, valid_out, pixel_x, pixel_y, frame_done
   );
endinterface

// File: rtl/layer_2_channel_packer.sv
// -----------------------------------------------------------------------------
// layer_2_channel_packer
// Packs NUM_CH consecutive 32-bit channel values into one DATA_IN_WIDTH-bit
// pixel word for the layer-2 feature-map banks and tracks the raster position
// of each emitted pixel over an IMG_SIZE x IMG_SIZE frame.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset
//   bus  : layer_2_channel_packer_if.slave
//          in : data_in, valid_in
//          out: ready_out, data_out, valid_out, pixel_x, pixel_y, frame_done
// Optional build macro:
//   LAYER_2_PACKER_RELU_EN : clamp lanes with the sign bit set to zero as they
//                            are written into the shadow register.
// -----------------------------------------------------------------------------
module layer_2_channel_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_CH        = 16,
   parameter int DATA_IN_WIDTH = 512,
   parameter int IMG_SIZE      = 208,
   parameter int COORD_WIDTH   = 8
) (
   input logic                       Clk,
   input logic                       Rst,
   layer_2_channel_packer_if.slave   bus
);

   localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CH_W-1:0]        LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [COORD_WIDTH-1:0] LAST_XY  = COORD_WIDTH'(IMG_SIZE - 1);

   typedef enum logic {FILL, EMIT} state_t;

   state_t                           state_q, state_d;
   logic [CH_W-1:0]                  ch_cnt_q, ch_cnt_d;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
   logic [DATA_IN_WIDTH-1:0]         data_out_q, data_out_d;
   logic [COORD_WIDTH-1:0]           pixel_x_q, pixel_x_d;
   logic [COORD_WIDTH-1:0]           pixel_y_q, pixel_y_d;
   logic [DATA_WIDTH-1:0]            lane_in;
   logic                             xfer;

`ifdef LAYER_2_PACKER_RELU_EN
   // Sign bit set covers negative values, -0.0 and negative NaN alike.
   assign lane_in = bus.data_in[DATA_WIDTH-1] ? '0 : bus.data_in;
`else
   assign lane_in = bus.data_in;
`endif

   assign xfer = bus.valid_in && (state_q == FILL);

   always_comb begin
      state_d    = state_q;
      ch_cnt_d   = ch_cnt_q;
      shadow_d   = shadow_q;
      data_out_d = data_out_q;
      pixel_x_d  = pixel_x_q;
      pixel_y_d  = pixel_y_q;
      case (state_q)
         FILL: begin
            if (xfer) begin
               shadow_d[ch_cnt_q] = lane_in;
               if (ch_cnt_q == LAST_CH) begin
                  // shadow_d already carries the final lane from this cycle
                  data_out_d = shadow_d;
                  ch_cnt_d   = '0;
                  state_d    = EMIT;
               end else begin
                  ch_cnt_d = ch_cnt_q + 1'b1;
               end
            end
         end
         EMIT: begin
            // Coordinates describe the pixel being emitted; step them as we leave.
            state_d = FILL;
            if (pixel_x_q == LAST_XY) begin
               pixel_x_d = '0;
               pixel_y_d = (pixel_y_q == LAST_XY) ? '0 : pixel_y_q + 1'b1;
            end else begin
               pixel_x_d = pixel_x_q + 1'b1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= FILL;
         ch_cnt_q   <= '0;
         shadow_q   <= '0;
         data_out_q <= '0;
         pixel_x_q  <= '0;
         pixel_y_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_cnt_q   <= ch_cnt_d;
         shadow_q   <= shadow_d;
         data_out_q <= data_out_d;
         pixel_x_q  <= pixel_x_d;
         pixel_y_q  <= pixel_y_d;
      end
   end

   assign bus.ready_out  = (state_q == FILL);
   assign bus.valid_out  = (state_q == EMIT);
   assign bus.data_out   = data_out_q;
   assign bus.pixel_x    = pixel_x_q;
   assign bus.pixel_y    = pixel_y_q;
   assign bus.frame_done = (state_q == EMIT) && (pixel_x_q == LAST_XY) && (pixel_y_q == LAST_XY);

endmodule

// File: tb/tb_layer_2_channel_packer.sv
module tb_layer_2_channel_packer;
   localparam int NUM_CH = 16;
   localparam int IMG    = 4;
   localparam int OBS_W  = 3 + 8 + 8 + 512;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   layer_2_channel_packer_if #(.DATA_WIDTH(32), .DATA_IN_WIDTH(512), .COORD_WIDTH(8)) bus ();

   layer_2_channel_packer #(
      .DATA_WIDTH(32), .NUM_CH(NUM_CH), .DATA_IN_WIDTH(512), .IMG_SIZE(IMG), .COORD_WIDTH(8)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: accepted lanes collected in a queue, pixel counter gives raster position.
   logic [31:0]  acc[$];
   bit           m_emit;
   logic [511:0] m_word;
   int           m_pix;

   function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef LAYER_2_PACKER_RELU_EN
      return d[31] ? 32'h0 : d;
`else
      return d;
`endif
   endfunction

   function automatic void model_reset();
      acc.delete();
      m_emit = 1'b0;
      m_word = '0;
      m_pix  = 0;
   endfunction

   function automatic void model_step(input bit v, input logic [31:0] d);
      if (m_emit) begin
         m_emit = 1'b0;
         m_pix++;
      end else if (v) begin
         acc.push_back(relu(d));
         if (acc.size() == NUM_CH) begin
            for (int k = 0; k < NUM_CH; k++) m_word[32*k +: 32] = acc[k];
            acc.delete();
            m_emit = 1'b1;
         end
      end
   endfunction

   function automatic logic [OBS_W-1:0] model_vec();
      int x = m_pix % IMG;
      int y = (m_pix / IMG) % IMG;
      logic fd = m_emit && (x == IMG-1) && (y == IMG-1);
      return {m_emit, ~m_emit, fd, 8'(x), 8'(y), m_word};
   endfunction

   function automatic logic [OBS_W-1:0] observe();
      return {bus.valid_out, bus.ready_out, bus.frame_done, bus.pixel_x, bus.pixel_y, bus.data_out};
   endfunction

   // Drive one cycle at the falling edge, step the model, land on the next falling edge.
   task automatic tick(input bit r, input bit v, input logic [31:0] d);
      Rst          = r;
      bus.valid_in = v;
      bus.data_in  = d;
      if (r) model_reset();
      else   model_step(v, d);
      @(negedge Clk);
   endtask

   task automatic test_reset();
      logic [OBS_W-1:0] rst_exp;
      rst_exp = {1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 512'd0};
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'h12345678);
      if (observe() !== rst_exp) begin
         mismatched++;
         $display("FAIL reset_state got=%h exp=%h", observe(), rst_exp);
      end
      compared++;
      if (observe() !== model_vec()) begin
         mismatched++;
         $display("FAIL reset_model got=%h exp=%h", observe(), model_vec());
      end
      compared++;
   endtask

   task automatic test_basic();
      for (int k = 0; k < NUM_CH; k++) begin
         tick(1'b0, 1'b1, 32'h3f800000 + k);
         if (observe() !== model_vec()) begin
            mismatched++;
            $display("FAIL basic cyc%0d got=%h exp=%h", k, observe(), model_vec());
         end
         compared++;
      end
      if (bus.valid_out !== 1'b1 || bus.ready_out !== 1'b0 || bus.pixel_x !== 8'd0 || bus.pixel_y !== 8'd0) begin
         mismatched++;
         $display("FAIL basic_emit v=%b r=%b x=%0d y=%0d exp v=1 r=0 x=0 y=0",
                  bus.valid_out, bus.ready_out, bus.pixel_x, bus.pixel_y);
      end
      compared++;
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.data_out[32*k +: 32] !== 32'h3f800000 + k) begin
            mismatched++;
            $display("FAIL basic_lane%0d got=%h exp=%h", k, bus.data_out[32*k +: 32], 32'h3f800000 + k);
         end
         compared++;
      end
      tick(1'b0, 1'b0, 32'h0);
      if (bus.valid_out !== 1'b0 || bus.ready_out !== 1'b1 || bus.data_out[31:0] !== 32'h3f800000) begin
         mismatched++;
         $display("FAIL basic_after v=%b r=%b lane0=%h exp v=0 r=1 lane0=3f800000",
                  bus.valid_out, bus.ready_out, bus.data_out[31:0]);
      end
      compared++;
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 2*NUM_CH; i++) begin
         if (i % 2 == 0) tick(1'b0, 1'b1, 32'h3f800000 + i/2);
         else            tick(1'b0, 1'b0, $urandom);
         if (observe() !== model_vec()) begin
            mismatched++;
            $display("FAIL gaps cyc%0d got=%h exp=%h", i, observe(), model_vec());
         end
         compared++;
         if (i == 2*NUM_CH-2) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (bus.valid_out !== 1'b1 || bus.data_out[32*k +: 32] !== 32'h3f800000 + k) begin
                  mismatched++;
                  $display("FAIL gaps_lane%0d v=%b got=%h exp=%h", k, bus.valid_out,
                           bus.data_out[32*k +: 32], 32'h3f800000 + k);
               end
               compared++;
            end
         end
      end
   endtask

   task automatic test_emit_ignore();
      for (int k = 0; k < NUM_CH; k++) tick(1'b0, 1'b1, 32'h00000100 + k);
      tick(1'b0, 1'b1, 32'hdeadbeef);
      if (observe() !== model_vec()) begin
         mismatched++;
         $display("FAIL emit_ignore_cyc got=%h exp=%h", observe(), model_vec());
      end
      compared++;
      for (int k = 0; k < NUM_CH; k++) tick(1'b0, 1'b1, 32'h00000200 + k);
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.valid_out !== 1'b1 || bus.data_out[32*k +: 32] !== 32'h00000200 + k) begin
            mismatched++;
            $display("FAIL emit_ignore_lane%0d v=%b got=%h exp=%h", k, bus.valid_out,
                     bus.data_out[32*k +: 32], 32'h00000200 + k);
         end
         compared++;
      end
      tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 7; k++) tick(1'b0, 1'b1, $urandom);
      tick(1'b1, 1'b1, 32'hffffffff);
      for (int k = 0; k < NUM_CH; k++) tick(1'b0, 1'b1, 32'(k + 1));
      if (bus.valid_out !== 1'b1 || bus.pixel_x !== 8'd0 || bus.pixel_y !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_mid_emit v=%b x=%0d y=%0d exp v=1 x=0 y=0", bus.valid_out, bus.pixel_x, bus.pixel_y);
      end
      compared++;
      for (int k = 0; k < NUM_CH; k++) begin
         if (bus.data_out[32*k +: 32] !== 32'(k + 1)) begin
            mismatched++;
            $display("FAIL reset_mid_lane%0d got=%h exp=%h", k, bus.data_out[32*k +: 32], 32'(k + 1));
         end
         compared++;
      end
      tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_frame();
      int npix = 0;
      int fd_cnt = 0;
      int fd_pix = -1;
      logic [7:0] last_x = 8'hff;
      logic [7:0] last_y = 8'hff;
      tick(1'b1, 1'b0, 32'h0);
      for (int cyc = 0; cyc < 3000 && npix < IMG*IMG + 1; cyc++) begin
         tick(1'b0, $urandom_range(0, 3) != 0, $urandom);
         if (observe() !== model_vec()) begin
            mismatched++;
            $display("FAIL frame cyc%0d got=%h exp=%h", cyc, observe(), model_vec());
         end
         compared++;
         if (bus.valid_out === 1'b1) begin
            npix++;
            last_x = bus.pixel_x;
            last_y = bus.pixel_y;
            if (bus.frame_done === 1'b1) begin
               fd_cnt++;
               fd_pix = npix;
            end
         end
      end
      if (npix != IMG*IMG + 1) begin
         mismatched++;
         $display("FAIL frame_timeout pixels=%0d exp=%0d", npix, IMG*IMG + 1);
      end
      compared++;
      if (fd_cnt != 1 || fd_pix != IMG*IMG) begin
         mismatched++;
         $display("FAIL frame_done count=%0d at_pixel=%0d exp count=1 at_pixel=%0d", fd_cnt, fd_pix, IMG*IMG);
      end
      compared++;
      if (last_x !== 8'd0 || last_y !== 8'd0) begin
         mismatched++;
         $display("FAIL frame_wrap x=%0d y=%0d exp x=0 y=0", last_x, last_y);
      end
      compared++;
      tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_relu();
      logic [31:0] vals[3];
      logic [31:0] expv[3];
      vals = '{32'hbf800000, 32'h80000000, 32'h3f800000};
`ifdef LAYER_2_PACKER_RELU_EN
      expv = '{32'h00000000, 32'h00000000, 32'h3f800000};
`else
      expv = '{32'hbf800000, 32'h80000000, 32'h3f800000};
`endif
      tick(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < NUM_CH; k++) tick(1'b0, 1'b1, (k < 3) ? vals[k] : 32'(k));
      for (int k = 0; k < 3; k++) begin
         if (bus.valid_out !== 1'b1 || bus.data_out[32*k +: 32] !== expv[k]) begin
            mismatched++;
            $display("FAIL relu_lane%0d v=%b got=%h exp=%h", k, bus.valid_out, bus.data_out[32*k +: 32], expv[k]);
         end
         compared++;
      end
      tick(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick(1'b0, $urandom_range(0, 4) != 0, $urandom);
         if (observe() !== model_vec()) begin
            mismatched++;
            $display("FAIL random cyc%0d got=%h exp=%h", cyc, observe(), model_vec());
         end
         compared++;
      end
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      model_reset();
      @(negedge Clk);
      test_reset();
      test_basic();
      test_gaps();
      test_emit_ignore();
      test_reset_mid();
      test_frame();
      test_relu();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
